// File: rtl/video_pkg.sv
// Shared video types, default panel timing and the colour-bar palette for the
// pixel-clock domain blocks.
package video_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    GRID    = 2'd0,
    BARS    = 2'd1,
    CHECKER = 2'd2,
    SOLID   = 2'd3
  } mode_e;

  localparam rgb_t RGB_WHITE = 24'hFFFFFF;
  localparam rgb_t RGB_BLACK = 24'h000000;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_COLORS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  localparam int DEF_HDISP     = 800;
  localparam int DEF_VDISP     = 480;
  localparam int DEF_HFP       = 40;
  localparam int DEF_HPULSE    = 48;
  localparam int DEF_HBP       = 40;
  localparam int DEF_VFP       = 13;
  localparam int DEF_VPULSE    = 3;
  localparam int DEF_VBP       = 29;
  localparam int DEF_GRID_LOG2 = 4;

  function automatic rgb_t bar_color(input logic [2:0] idx);
    return BAR_COLORS[idx];
  endfunction

endpackage

// File: rtl/video_if.sv
// Parallel video bus towards the DAC: syncs, blanking, pixel colour and pixel clock.
interface video_if;
  logic        HS;
  logic        VS;
  logic        BLANK;
  logic [23:0] RGB;
  logic        CLK;

  modport master (output HS, VS, BLANK, RGB, CLK);
  modport slave  (input  HS, VS, BLANK, RGB, CLK);
endinterface

// File: rtl/vga_pattern_gen.sv
// Test-pattern colour source; fed with counter-stage pixel state so its
// registered RGB lines up with the timing generator's output register.
module vga_pattern_gen
  import video_pkg::*;
#(
  parameter int HDISP     = DEF_HDISP,
  parameter int GRID_LOG2 = DEF_GRID_LOG2
) (
  input  logic                 pixel_clk,
  input  logic                 pixel_rst,
  input  logic                 vis,
  input  logic [GRID_LOG2:0]   px,
  input  logic [GRID_LOG2:0]   py,
  input  logic                 line_start,
  input  mode_e                mode_l,
  input  rgb_t                 solid_l,
  output rgb_t                 rgb
);

  localparam int BW  = HDISP / 8;
  localparam int BCW = $clog2(BW + 1);

  logic [2:0]     bar_idx_r;
  logic [BCW-1:0] bar_cnt_r;
  logic [2:0]     bar_cur_s;
  logic [BCW-1:0] cnt_cur_s;
  logic           grid_on_s;
  logic           check_on_s;
  rgb_t           pat_s;

  // Current bar position (restarted at line start) and per-mode colour select.
  always_comb begin
    bar_cur_s  = line_start ? 3'd0 : bar_idx_r;
    cnt_cur_s  = line_start ? '0 : bar_cnt_r;
    grid_on_s  = (px[GRID_LOG2-1:0] == '0) || (py[GRID_LOG2-1:0] == '0);
    check_on_s = px[GRID_LOG2] ^ py[GRID_LOG2];
    case (mode_l)
      GRID:    pat_s = grid_on_s ? RGB_WHITE : RGB_BLACK;
      BARS:    pat_s = bar_color(bar_cur_s);
      CHECKER: pat_s = check_on_s ? RGB_WHITE : RGB_BLACK;
      SOLID:   pat_s = solid_l;
      default: pat_s = RGB_BLACK;
    endcase
  end

  // Bar sub-counter steps every BW visible pixels; bar 7 holds and takes the remainder.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      bar_idx_r <= 3'd0;
      bar_cnt_r <= '0;
      rgb       <= RGB_BLACK;
    end else begin
      rgb <= vis ? pat_s : RGB_BLACK;
      if (vis) begin
        if (bar_cur_s == 3'd7) begin
          bar_idx_r <= bar_cur_s;
          bar_cnt_r <= cnt_cur_s;
        end else if (cnt_cur_s == BCW'(BW - 1)) begin
          bar_idx_r <= bar_cur_s + 3'd1;
          bar_cnt_r <= '0;
        end else begin
          bar_idx_r <= bar_cur_s;
          bar_cnt_r <= cnt_cur_s + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing master: h/v counters, sync decode, pixel coordinates
// and frame/line strobes, all presented through one aligned output register.
module vga_timing_gen
  import video_pkg::*;
#(
  parameter int HDISP     = DEF_HDISP,
  parameter int VDISP     = DEF_VDISP,
  parameter int HFP       = DEF_HFP,
  parameter int HPULSE    = DEF_HPULSE,
  parameter int HBP       = DEF_HBP,
  parameter int VFP       = DEF_VFP,
  parameter int VPULSE    = DEF_VPULSE,
  parameter int VBP       = DEF_VBP,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int GRID_LOG2 = DEF_GRID_LOG2
) (
  input  logic                       pixel_clk,
  input  logic                       pixel_rst,
  input  logic [1:0]                 mode,
  input  rgb_t                       solid_rgb,
  video_if.master                    video_ifm,
  output logic [$clog2(HDISP)-1:0]   x,
  output logic [$clog2(VDISP)-1:0]   y,
  output logic                       sol,
  output logic                       sof
);

  localparam int HSYNC_END = HFP + HPULSE;
  localparam int HSTART    = HFP + HPULSE + HBP;
  localparam int HTOTAL    = HSTART + HDISP;
  localparam int VSYNC_END = VFP + VPULSE;
  localparam int VSTART    = VFP + VPULSE + VBP;
  localparam int VTOTAL    = VSTART + VDISP;
  localparam int HW        = $clog2(HTOTAL);
  localparam int VW        = $clog2(VTOTAL);
  localparam int XW        = $clog2(HDISP);
  localparam int YW        = $clog2(VDISP);

  if (HDISP < 8 || HFP < 1 || HPULSE < 1 || HBP < 1 || VFP < 1 || VPULSE < 1 ||
      VBP < 1 || XW <= GRID_LOG2 || YW <= GRID_LOG2) begin : g_bad_params
    $error("vga_timing_gen: HDISP must be >= 8, porch/pulse widths >= 1, display larger than a grid cell");
  end

  logic [HW-1:0] h_cnt_r;
  logic [VW-1:0] v_cnt_r;
  logic [XW-1:0] x_i_r;
  logic [YW-1:0] y_i_r;
  mode_e         mode_r;
  rgb_t          solid_r;
  logic          hs_r;
  logic          vs_r;
  logic          blank_r;
  rgb_t          rgb_s;
  logic          h_end_s;
  logic          v_end_s;
  logic          hs_s;
  logic          vs_s;
  logic          v_vis_s;
  logic          vis_s;
  logic          sol_s;
  logic          sof_s;

  // Region decode of the current counter state.
  always_comb begin
    h_end_s = (h_cnt_r == HW'(HTOTAL - 1));
    v_end_s = (v_cnt_r == VW'(VTOTAL - 1));
    hs_s    = (h_cnt_r >= HW'(HFP)) && (h_cnt_r < HW'(HSYNC_END));
    vs_s    = (v_cnt_r >= VW'(VFP)) && (v_cnt_r < VW'(VSYNC_END));
    v_vis_s = (v_cnt_r >= VW'(VSTART));
    vis_s   = v_vis_s && (h_cnt_r >= HW'(HSTART));
    sol_s   = vis_s && (h_cnt_r == HW'(HSTART));
    sof_s   = sol_s && (v_cnt_r == VW'(VSTART));
  end

  // Raster counters, pixel counters and the once-per-frame mode/colour shadow.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
      x_i_r   <= '0;
      y_i_r   <= '0;
      mode_r  <= GRID;
      solid_r <= RGB_BLACK;
    end else begin
      if (h_end_s) begin
        h_cnt_r <= '0;
        v_cnt_r <= v_end_s ? '0 : v_cnt_r + 1'b1;
      end else begin
        h_cnt_r <= h_cnt_r + 1'b1;
      end
      if (h_end_s) begin
        x_i_r <= '0;
      end else if (vis_s) begin
        x_i_r <= x_i_r + 1'b1;
      end
      if (h_end_s && v_end_s) begin
        y_i_r <= '0;
      end else if (h_end_s && v_vis_s) begin
        y_i_r <= y_i_r + 1'b1;
      end
      if (h_cnt_r == '0 && v_cnt_r == '0) begin
        mode_r  <= mode_e'(mode);
        solid_r <= solid_rgb;
      end
    end
  end

  // Output register; RGB is registered in the same stage inside the pattern source.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hs_r    <= ~HS_POL;
      vs_r    <= ~VS_POL;
      blank_r <= 1'b0;
      x       <= '0;
      y       <= '0;
      sol     <= 1'b0;
      sof     <= 1'b0;
    end else begin
      hs_r    <= hs_s ? HS_POL : ~HS_POL;
      vs_r    <= vs_s ? VS_POL : ~VS_POL;
      blank_r <= vis_s;
      x       <= vis_s ? x_i_r : '0;
      y       <= vis_s ? y_i_r : '0;
      sol     <= sol_s;
      sof     <= sof_s;
    end
  end

  vga_pattern_gen #(
    .HDISP     (HDISP),
    .GRID_LOG2 (GRID_LOG2)
  ) u_pattern (
    .pixel_clk  (pixel_clk),
    .pixel_rst  (pixel_rst),
    .vis        (vis_s),
    .px         (x_i_r[GRID_LOG2:0]),
    .py         (y_i_r[GRID_LOG2:0]),
    .line_start (sol_s),
    .mode_l     (mode_r),
    .solid_l    (solid_r),
    .rgb        (rgb_s)
  );

  assign video_ifm.HS    = hs_r;
  assign video_ifm.VS    = vs_r;
  assign video_ifm.BLANK = blank_r;
  assign video_ifm.RGB   = rgb_s;
  assign video_ifm.CLK   = pixel_clk;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a small inverted-polarity panel (A) for frame timing, mode
// switching and reset, and an 804-wide panel (B) for grid and colour-bar pixels.
module tb_vga_timing_gen;
  import video_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, b_rst;
  logic [1:0] a_mode, b_mode;
  rgb_t       a_solid, b_solid;
  logic [5:0] a_x;
  logic [4:0] a_y;
  logic       a_sol, a_sof;
  logic [9:0] b_x;
  logic [5:0] b_y;
  logic       b_sol, b_sof;

  video_if if_a ();
  video_if if_b ();

  int n_checks = 0;
  int n_fail   = 0;
  bit b_dead   = 1'b0;

  // A: HTOTAL = 2+3+4+64 = 73, VTOTAL = 1+2+3+32 = 38, frame = 2774 cycles.
  vga_timing_gen #(
    .HDISP(64), .VDISP(32), .HFP(2), .HPULSE(3), .HBP(4),
    .VFP(1), .VPULSE(2), .VBP(3), .HS_POL(1'b1), .VS_POL(1'b1), .GRID_LOG2(4)
  ) u_a (
    .pixel_clk(clk), .pixel_rst(a_rst), .mode(a_mode), .solid_rgb(a_solid),
    .video_ifm(if_a), .x(a_x), .y(a_y), .sol(a_sol), .sof(a_sof)
  );

  // B: HTOTAL = 40+48+40+804 = 932, VTOTAL = 1+1+1+34 = 37, bar width 100.
  vga_timing_gen #(
    .HDISP(804), .VDISP(34), .HFP(40), .HPULSE(48), .HBP(40),
    .VFP(1), .VPULSE(1), .VBP(1), .HS_POL(1'b0), .VS_POL(1'b0), .GRID_LOG2(4)
  ) u_b (
    .pixel_clk(clk), .pixel_rst(b_rst), .mode(b_mode), .solid_rgb(b_solid),
    .video_ifm(if_b), .x(b_x), .y(b_y), .sol(b_sol), .sof(b_sof)
  );

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (if_a.HS !== 1'b0) begin n_fail++; $display("FAIL reset_a_hs: got %b want 0", if_a.HS); end
    n_checks++; if (if_a.VS !== 1'b0) begin n_fail++; $display("FAIL reset_a_vs: got %b want 0", if_a.VS); end
    n_checks++; if (if_a.BLANK !== 1'b0) begin n_fail++; $display("FAIL reset_a_blank: got %b want 0", if_a.BLANK); end
    n_checks++; if (if_a.RGB !== 24'h000000) begin n_fail++; $display("FAIL reset_a_rgb: got %h want 000000", if_a.RGB); end
    n_checks++; if (a_x !== 6'd0 || a_y !== 5'd0) begin n_fail++; $display("FAIL reset_a_xy: got %0d,%0d want 0,0", a_x, a_y); end
    n_checks++; if (a_sol !== 1'b0 || a_sof !== 1'b0) begin n_fail++; $display("FAIL reset_a_strobes: got sol=%b sof=%b want 0,0", a_sol, a_sof); end
    n_checks++; if (if_b.HS !== 1'b1 || if_b.VS !== 1'b1) begin n_fail++; $display("FAIL reset_b_sync: got hs=%b vs=%b want 1,1", if_b.HS, if_b.VS); end
    n_checks++; if (if_a.CLK !== clk) begin n_fail++; $display("FAIL reset_a_clk: got %b want %b", if_a.CLK, clk); end
  endtask

  task automatic test_first_sof(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    a_rst = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk); #1;
      if (a_sof) begin n = i; break; end
    end
    // 9 + 6*73 + 1
    n_checks++; if (n !== 448) begin n_fail++; $display("FAIL %s: first sof after %0d cycles, want 448", tag, n); end
  endtask

  task automatic test_frames();
    int hs_n, vs_n, bl_n, sol_n, sof_at, bad_rgb, bad_align;
    bad_rgb = 0;
    bad_align = 0;
    for (int f = 0; f < 2; f++) begin
      hs_n = 0; vs_n = 0; bl_n = 0; sol_n = 0; sof_at = 0;
      for (int i = 1; i <= 2774; i++) begin
        @(posedge clk); #1;
        if (if_a.HS === 1'b1) hs_n++;
        if (if_a.VS === 1'b1) vs_n++;
        if (if_a.BLANK === 1'b1) bl_n++;
        if (a_sol === 1'b1) sol_n++;
        if (if_a.BLANK !== 1'b1 && if_a.RGB !== 24'h000000) bad_rgb++;
        if (a_sof === 1'b1) begin
          if (sof_at == 0) sof_at = i;
          if (a_sol !== 1'b1 || a_x !== 6'd0 || a_y !== 5'd0) bad_align++;
        end
      end
      n_checks++; if (sof_at !== 2774) begin n_fail++; $display("FAIL sof_period f%0d: got %0d want 2774", f, sof_at); end
      n_checks++; if (hs_n !== 114) begin n_fail++; $display("FAIL hs_active f%0d: got %0d want 114", f, hs_n); end
      n_checks++; if (vs_n !== 146) begin n_fail++; $display("FAIL vs_active f%0d: got %0d want 146", f, vs_n); end
      n_checks++; if (bl_n !== 2048) begin n_fail++; $display("FAIL blank_high f%0d: got %0d want 2048", f, bl_n); end
      n_checks++; if (sol_n !== 32) begin n_fail++; $display("FAIL sol_count f%0d: got %0d want 32", f, sol_n); end
    end
    n_checks++; if (bad_rgb !== 0) begin n_fail++; $display("FAIL rgb_in_blank: got %0d nonzero, want 0", bad_rgb); end
    n_checks++; if (bad_align !== 0) begin n_fail++; $display("FAIL sof_alignment: got %0d bad, want 0", bad_align); end
  endtask

  task automatic test_mode_switch();
    int phase, bad_grid, bad_solid, found;
    rgb_t exp;
    logic [5:0] xv;
    logic [4:0] yv;
    found = 0;
    for (int i = 0; i < 2774; i++) begin
      @(posedge clk); #1;
      if (if_a.BLANK === 1'b1 && a_y == 5'd16) begin found = 1; break; end
    end
    n_checks++; if (found !== 1) begin n_fail++; $display("FAIL mode_switch_line: got found=%0d want 1", found); end
    a_mode  = 2'd3;
    a_solid = 24'h123456;
    phase = 0; bad_grid = 0; bad_solid = 0;
    for (int i = 0; i < 3 * 2774; i++) begin
      @(posedge clk); #1;
      if (a_sof === 1'b1) phase++;
      if (phase == 2) break;
      if (if_a.BLANK === 1'b1) begin
        xv = a_x; yv = a_y;
        if (phase == 0) begin
          exp = (xv[3:0] == 4'd0 || yv[3:0] == 4'd0) ? 24'hFFFFFF : 24'h000000;
          if (if_a.RGB !== exp) bad_grid++;
        end else begin
          if (if_a.RGB !== 24'h123456) bad_solid++;
        end
      end
    end
    n_checks++; if (phase !== 2) begin n_fail++; $display("FAIL mode_switch_frames: got %0d sof, want 2", phase); end
    n_checks++; if (bad_grid !== 0) begin n_fail++; $display("FAIL mode_switch_grid: got %0d bad pixels, want 0", bad_grid); end
    n_checks++; if (bad_solid !== 0) begin n_fail++; $display("FAIL mode_switch_solid: got %0d bad pixels, want 0", bad_solid); end
  endtask

  task automatic test_mid_reset();
    int found;
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (if_a.BLANK === 1'b1 && a_x == 6'd40 && a_y == 5'd20) begin found = 1; break; end
    end
    n_checks++; if (found !== 1) begin n_fail++; $display("FAIL mid_reset_pixel: got found=%0d want 1", found); end
    a_rst = 1'b1;
    #1;
    n_checks++; if (if_a.HS !== 1'b0 || if_a.VS !== 1'b0) begin n_fail++; $display("FAIL mid_reset_sync: got hs=%b vs=%b want 0,0", if_a.HS, if_a.VS); end
    n_checks++; if (if_a.BLANK !== 1'b0) begin n_fail++; $display("FAIL mid_reset_blank: got %b want 0", if_a.BLANK); end
    n_checks++; if (if_a.RGB !== 24'h000000) begin n_fail++; $display("FAIL mid_reset_rgb: got %h want 000000", if_a.RGB); end
    n_checks++; if (a_x !== 6'd0 || a_y !== 5'd0) begin n_fail++; $display("FAIL mid_reset_xy: got %0d,%0d want 0,0", a_x, a_y); end
    test_first_sof("mid_reset_sof");
  endtask

  task automatic test_grid_bars();
    int tx [13] = '{0, 5, 16, 3, 99, 100, 200, 350, 450, 599, 699, 700, 803};
    int ty [13] = '{5, 5, 7, 32, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    rgb_t ex [13] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'hFFFFFF,
                      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF,
                      24'hFF0000, 24'h0000FF, 24'h000000, 24'h000000};
    int found;
    b_mode = 2'd0;
    @(negedge clk);
    b_rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      if (k == 4 && !b_dead) begin
        b_mode = 2'd1;
        found = 0;
        for (int i = 0; i < 40000; i++) begin
          @(posedge clk); #1;
          if (b_sof === 1'b1) begin found = 1; break; end
        end
        n_checks++; if (found !== 1) begin n_fail++; b_dead = 1'b1; $display("FAIL bars_frame_start: got found=%0d want 1", found); end
      end
      if (!b_dead) begin
        found = 0;
        for (int i = 0; i < 40000; i++) begin
          @(posedge clk); #1;
          if (if_b.BLANK === 1'b1 && b_x == 10'(tx[k]) && b_y == 6'(ty[k])) begin found = 1; break; end
        end
        n_checks++;
        if (found !== 1) begin
          n_fail++; b_dead = 1'b1;
          $display("FAIL pixel_%0d_%0d: not reached, want %h", tx[k], ty[k], ex[k]);
        end else if (if_b.RGB !== ex[k]) begin
          n_fail++;
          $display("FAIL pixel_%0d_%0d: got %h want %h", tx[k], ty[k], if_b.RGB, ex[k]);
        end
      end
    end
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_mode = 2'd0; b_mode = 2'd0;
    a_solid = 24'h000000; b_solid = 24'h000000;
    test_reset();
    test_first_sof("first_sof");
    test_frames();
    test_mode_switch();
    test_mid_reset();
    test_grid_bars();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised successor of the single-mode VGA generator: produces HS/VS/BLANK for any panel geometry with configurable porches and sync polarities, pixel coordinates, frame/line strobes, and a selectable test-pattern RGB source. Sits between the pixel-clock domain and the video DAC interface (`video_if`). It is the timing master that the future framebuffer reader will slave to via `x`, `y`, `sof` and `sol`.

## Interface
- HDISP, 800: visible pixels per line
- VDISP, 480: visible lines per frame
- HFP / HPULSE / HBP, 40 / 48 / 40: horizontal front porch, sync, back porch (pixels)
- VFP / VPULSE / VBP, 13 / 3 / 29: vertical front porch, sync, back porch (lines)
- HS_POL / VS_POL, 0 / 0: asserted level of HS / VS
- GRID_LOG2, 4: grid and checker cell size is 2^GRID_LOG2 pixels
- pixel_clk  in  1  pixel clock; also driven onto video_ifm.CLK
- pixel_rst  in  1  asynchronous, active-high reset
- mode  in  2  pattern select: 0 grid, 1 colour bars, 2 checker, 3 solid
- solid_rgb  in  24  colour for mode 3
- video_ifm  modport master  -  HS, VS, BLANK (1 = visible pixel), RGB[23:0], CLK
- x  out  $clog2(HDISP)  column of the pixel on RGB; 0 outside the visible area
- y  out  $clog2(VDISP)  row of the pixel on RGB; 0 outside the visible area
- sol  out  1  one-cycle pulse with the first visible pixel of each line
- sof  out  1  one-cycle pulse with pixel (0,0) of each frame

## Operation
- HTOTAL = HFP+HPULSE+HBP+HDISP and VTOTAL = VFP+VPULSE+VBP+VDISP.
- h_cnt counts 0..HTOTAL-1 and then wraps. v_cnt advances when h_cnt wraps and counts 0..VTOTAL-1. Both counters wrap in the same cycle at (HTOTAL-1, VTOTAL-1).
- Regions per axis, in order: front porch, sync, back porch, display. Example: HS is asserted for HFP ≤ h_cnt < HFP+HPULSE.
- Visible area: h_cnt ≥ HFP+HPULSE+HBP and v_cnt ≥ VFP+VPULSE+VBP.
- Pixel counters x_i and y_i increment only while visible. x_i clears at end of line. y_i clears at end of frame.
- Mode latch: `mode` and `solid_rgb` are sampled into a shadow register only at h_cnt=0, v_cnt=0. A change mid-frame takes effect from the next frame.
- Grid (mode 0): white (24'hFFFFFF) when x[GRID_LOG2-1:0]==0 or y[GRID_LOG2-1:0]==0; otherwise black.
- Colour bars (mode 1): 8 bars in the order white, yellow, cyan, green, magenta, red, blue, black.
  - Bar width is BW = HDISP/8 (integer division).
  - Bar index comes from a sequential sub-counter that resets at line start and advances every BW pixels, saturating at 7. Bar 7 absorbs any remainder.
  - No divider is used.
- Checker (mode 2): white when x[GRID_LOG2] XOR y[GRID_LOG2] is 1; otherwise black.
- Solid (mode 3): the latched solid_rgb.
- RGB is forced to 0 whenever BLANK=0.

## Timing
- Single-stage output register. HS, VS, BLANK, RGB, x, y, sol and sof are all registered and mutually aligned, one cycle after the h_cnt/v_cnt state that generates them.
- Reset values (asynchronous):
  - counters, x, y, sol, sof, BLANK, RGB: 0
  - HS = ~HS_POL, VS = ~VS_POL
  - latched mode = 0
- First cycle after reset release: h_cnt=0, v_cnt=0. The first `sof` appears (HFP+HPULSE+HBP) + (VFP+VPULSE+VBP)·HTOTAL + 1 cycles after release.
- Period between sof pulses is exactly HTOTAL·VTOTAL cycles. For the defaults, HTOTAL=928, VTOTAL=525, period = 487200.
- Reset asserted mid-frame: all outputs take their reset values immediately. Timing restarts from (0,0).
- sol also fires on the sof cycle.

## Structure
- Package `video_pkg`: rgb_t (24-bit), mode_e enum (GRID, BARS, CHECKER, SOLID), bar colour constant array, and default timing localparams.
- Sub-module `vga_pattern_gen`: takes the registered visible flag, x, y and line start, plus the latched mode and colour. Owns the bar sub-counter and produces the RGB value.
- Counters and sync decode stay in the top module.
- Elaboration check: HDISP ≥ 8 and every porch/pulse parameter ≥ 1.

## Test plan
- Defaults, run 2 frames: HS low for 48 cycles every 928; VS low for 3·928 cycles every 487200; BLANK high for exactly 800×480 cycles per frame.
- Mode 0: pixels (0,5), (16,7) and (3,32) are 24'hFFFFFF; pixel (5,5) is 0. RGB=0 whenever BLANK=0.
- Mode 1 with HDISP=804: bar boundaries at x=100, 200, … 700; bar 7 spans x=700..803 and is 0. Pixel x=100 is 24'hFFFF00.
- Mode switched 0→3 (solid_rgb=24'h123456) at mid-frame line 200: rest of frame is grid; next frame is all 24'h123456.
- HS_POL=1, VS_POL=1, HDISP=64, VDISP=32, porches 2/3/4 and 1/2/3: polarities inverted, sof period = 73·38 = 2774.
- pixel_rst pulsed at x=400, y=100: outputs go to reset values the same cycle. The next sof arrives at the expected post-reset offset.
